// File: rtl/lmc1992_rx_if.sv
// Microwire command stream into the LMC1992 responder and decoded mixer settings out.
// The master side is the shifter's microwire master; the slave side is the responder.
interface lmc1992_rx_if;
    logic       mw_start;
    logic       mw_bit_en;
    logic       mw_clk;
    logic       mw_data;
    logic       mw_done;
    logic [1:0] mix;
    logic [3:0] bass;
    logic [3:0] treble;
    logic [5:0] master_vol;
    logic [4:0] left_vol;
    logic [4:0] right_vol;
    logic       cmd_valid;
    logic       cmd_err;

    modport master (
        output mw_start, mw_bit_en, mw_clk, mw_data, mw_done,
        input  mix, bass, treble, master_vol, left_vol, right_vol, cmd_valid, cmd_err
    );

    modport slave (
        input  mw_start, mw_bit_en, mw_clk, mw_data, mw_done,
        output mix, bass, treble, master_vol, left_vol, right_vol, cmd_valid, cmd_err
    );
endinterface

// File: rtl/lmc1992_rx.sv
// LMC1992 microwire responder: assembles 11-bit command words from the masked serial
// stream and decodes them into registered volume, tone and mix settings.
module lmc1992_rx #(
    parameter logic [1:0] DEV_ADDR = 2'b10
) (
    input logic         clk32,
    input logic         resb,
    lmc1992_rx_if.slave mw
);

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

    state_t      state_q, state_d;
    logic [10:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_prev_q, done_prev_d;
    logic [1:0]  mix_q, mix_d;
    logic [3:0]  bass_q, bass_d;
    logic [3:0]  treble_q, treble_d;
    logic [5:0]  master_vol_q, master_vol_d;
    logic [4:0]  left_vol_q, left_vol_d;
    logic [4:0]  right_vol_q, right_vol_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_err_q, cmd_err_d;

    logic start_bit;
    logic cap_bit;
    logic done_rise;
    logic cmd_ok;

    function automatic logic [3:0] sat_tone(input logic [3:0] v);
        return (v > 4'd12) ? 4'd12 : v;
    endfunction

    function automatic logic [5:0] sat_master(input logic [5:0] v);
        return (v > 6'd40) ? 6'd40 : v;
    endfunction

    function automatic logic [4:0] sat_chan(input logic [4:0] v);
        return (v > 5'd20) ? 5'd20 : v;
    endfunction

    assign start_bit = mw.mw_start & mw.mw_bit_en;
    assign cap_bit   = mw.mw_bit_en & mw.mw_clk;
    assign done_rise = mw.mw_done & ~done_prev_q;
    assign cmd_ok    = (cnt_q == 5'd11) && (sr_q[10:9] == DEV_ADDR) && (sr_q[8:6] <= 3'd5);

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_bit) state_d = SHIFT;
            SHIFT:   if (!start_bit && done_rise) state_d = DECODE;
            DECODE:  state_d = start_bit ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        done_prev_d  = mw.mw_done;
        mix_d        = mix_q;
        bass_d       = bass_q;
        treble_d     = treble_q;
        master_vol_d = master_vol_q;
        left_vol_d   = left_vol_q;
        right_vol_d  = right_vol_q;
        cmd_valid_d  = 1'b0;
        cmd_err_d    = 1'b0;

        // A start strobe always opens a fresh word, dropping any partial one.
        if (start_bit) begin
            sr_d  = cap_bit ? {10'd0, mw.mw_data} : 11'd0;
            cnt_d = cap_bit ? 5'd1 : 5'd0;
        end else if (state_q == SHIFT && cap_bit) begin
            sr_d  = {sr_q[9:0], mw.mw_data};
            cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end

        if (state_q == DECODE) begin
            if (cmd_ok) begin
                cmd_valid_d = 1'b1;
                case (sr_q[8:6])
                    3'd0:    mix_d        = sr_q[1:0];
                    3'd1:    bass_d       = sat_tone(sr_q[3:0]);
                    3'd2:    treble_d     = sat_tone(sr_q[3:0]);
                    3'd3:    master_vol_d = sat_master(sr_q[5:0]);
                    3'd4:    right_vol_d  = sat_chan(sr_q[4:0]);
                    3'd5:    left_vol_d   = sat_chan(sr_q[4:0]);
                    default: cmd_valid_d  = 1'b1;
                endcase
            end else begin
                cmd_err_d = 1'b1;
            end
        end
    end

    // Edge detector resets high so a done level present at reset release is not an edge.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            sr_q         <= 11'd0;
            cnt_q        <= 5'd0;
            done_prev_q  <= 1'b1;
            mix_q        <= 2'b01;
            bass_q       <= 4'd6;
            treble_q     <= 4'd6;
            master_vol_q <= 6'd40;
            left_vol_q   <= 5'd20;
            right_vol_q  <= 5'd20;
            cmd_valid_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            done_prev_q  <= done_prev_d;
            mix_q        <= mix_d;
            bass_q       <= bass_d;
            treble_q     <= treble_d;
            master_vol_q <= master_vol_d;
            left_vol_q   <= left_vol_d;
            right_vol_q  <= right_vol_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign mw.mix        = mix_q;
    assign mw.bass       = bass_q;
    assign mw.treble     = treble_q;
    assign mw.master_vol = master_vol_q;
    assign mw.left_vol   = left_vol_q;
    assign mw.right_vol  = right_vol_q;
    assign mw.cmd_valid  = cmd_valid_q;
    assign mw.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_lmc1992_rx.sv
// Scoreboard bench for lmc1992_rx: each finished transfer pushes its expected outcome,
// and every cmd_valid/cmd_err pulse pops one entry and compares all settings.
`timescale 1ns/1ps
module tb_lmc1992_rx;

    typedef struct {
        bit         ok;
        logic [1:0] mix;
        logic [3:0] bass;
        logic [3:0] treble;
        logic [5:0] mv;
        logic [4:0] lv;
        logic [4:0] rv;
    } exp_t;

    logic clk32 = 1'b0;
    logic resb;
    lmc1992_rx_if bus();

    lmc1992_rx #(.DEV_ADDR(2'b10)) dut (
        .clk32 (clk32),
        .resb  (resb),
        .mw    (bus.slave)
    );

    always #15.625 clk32 = ~clk32;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [1:0]  m_mix;
    logic [3:0]  m_bass, m_treble;
    logic [5:0]  m_mv;
    logic [4:0]  m_lv, m_rv;
    logic [10:0] m_word;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp_v, $time);
    endtask

    task automatic model_reset();
        m_mix = 2'b01; m_bass = 4'd6; m_treble = 4'd6;
        m_mv = 6'd40; m_lv = 5'd20; m_rv = 5'd20;
    endtask

    task automatic push_expect();
        exp_t e;
        e.ok = (m_cnt == 11) && (m_word[10:9] == 2'b10) && (m_word[8:6] <= 3'd5);
        if (e.ok) begin
            case (m_word[8:6])
                3'd0: m_mix    = m_word[1:0];
                3'd1: m_bass   = (m_word[3:0] > 4'd12) ? 4'd12 : m_word[3:0];
                3'd2: m_treble = (m_word[3:0] > 4'd12) ? 4'd12 : m_word[3:0];
                3'd3: m_mv     = (m_word[5:0] > 6'd40) ? 6'd40 : m_word[5:0];
                3'd4: m_rv     = (m_word[4:0] > 5'd20) ? 5'd20 : m_word[4:0];
                default: m_lv  = (m_word[4:0] > 5'd20) ? 5'd20 : m_word[4:0];
            endcase
        end
        e.mix = m_mix; e.bass = m_bass; e.treble = m_treble;
        e.mv = m_mv; e.lv = m_lv; e.rv = m_rv;
        sb_q.push_back(e);
    endtask

    // Shift nbits of data (MSB first) with the given mask; optionally raise mw_done
    // (separately or together with the last bit) and check the pulse latency and width.
    task automatic xfer(input logic [15:0] data, input logic [15:0] mask, input int nbits,
                        input bit with_last, input bit finish);
        m_word = 11'd0;
        m_cnt  = 0;
        for (int i = nbits - 1; i >= 0; i--) begin
            @(posedge clk32); #1;
            bus.mw_bit_en = 1'b1;
            bus.mw_start  = (i == nbits - 1);
            bus.mw_clk    = mask[i];
            bus.mw_data   = data[i];
            if (i == nbits - 1) bus.mw_done = 1'b0;
            if (i == 0 && finish && with_last) bus.mw_done = 1'b1;
            if (mask[i]) begin
                m_word = {m_word[9:0], data[i]};
                if (m_cnt < 31) m_cnt++;
            end
            @(posedge clk32); #1;
            bus.mw_bit_en = 1'b0;
            bus.mw_start  = 1'b0;
            bus.mw_clk    = 1'b0;
            bus.mw_data   = 1'b0;
        end
        if (finish) begin
            if (!with_last) begin
                bus.mw_done = 1'b1;
                @(posedge clk32);
            end
            @(posedge clk32);
            push_expect();
            @(negedge clk32);
            chk("pulse_lat", {31'd0, bus.cmd_valid | bus.cmd_err}, 32'd1);
            @(negedge clk32);
            chk("pulse_width", {31'd0, bus.cmd_valid | bus.cmd_err}, 32'd0);
        end
    endtask

    task automatic chk_settings(input string tag);
        chk({tag, "_mix"},    {30'd0, bus.mix},        {30'd0, m_mix});
        chk({tag, "_bass"},   {28'd0, bus.bass},       {28'd0, m_bass});
        chk({tag, "_treble"}, {28'd0, bus.treble},     {28'd0, m_treble});
        chk({tag, "_mvol"},   {26'd0, bus.master_vol}, {26'd0, m_mv});
        chk({tag, "_lvol"},   {27'd0, bus.left_vol},   {27'd0, m_lv});
        chk({tag, "_rvol"},   {27'd0, bus.right_vol},  {27'd0, m_rv});
    endtask

    always @(negedge clk32) begin
        if (bus.cmd_valid || bus.cmd_err) begin
            chk("excl", {31'd0, bus.cmd_valid & bus.cmd_err}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexp_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("cmd_valid", {31'd0, bus.cmd_valid}, {31'd0, mon_e.ok});
                chk("cmd_err",   {31'd0, bus.cmd_err},   {31'd0, !mon_e.ok});
                chk("sb_mix",    {30'd0, bus.mix},        {30'd0, mon_e.mix});
                chk("sb_bass",   {28'd0, bus.bass},       {28'd0, mon_e.bass});
                chk("sb_treble", {28'd0, bus.treble},     {28'd0, mon_e.treble});
                chk("sb_mvol",   {26'd0, bus.master_vol}, {26'd0, mon_e.mv});
                chk("sb_lvol",   {27'd0, bus.left_vol},   {27'd0, mon_e.lv});
                chk("sb_rvol",   {27'd0, bus.right_vol},  {27'd0, mon_e.rv});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        resb = 1'b0;
        bus.mw_start = 1'b0; bus.mw_bit_en = 1'b0; bus.mw_clk = 1'b0;
        bus.mw_data = 1'b0;  bus.mw_done = 1'b1;
        model_reset();
        repeat (3) @(posedge clk32);
        #1;
        chk_settings("rst");
        chk("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        chk("rst_err",   {31'd0, bus.cmd_err},   32'd0);
        resb = 1'b1;
        repeat (4) begin
            @(negedge clk32);
            chk("rst_rel_nopulse", {31'd0, bus.cmd_valid | bus.cmd_err}, 32'd0);
        end

        xfer(16'h04E8, 16'h07FF, 16, 1'b0, 1'b1);  // master 40
        xfer(16'h04D4, 16'h07FF, 16, 1'b0, 1'b1);  // master 20
        xfer(16'h055F, 16'h07FF, 16, 1'b0, 1'b1);  // left 31 -> 20
        xfer(16'h02E8, 16'h07FF, 16, 1'b0, 1'b1);  // wrong address
        xfer(16'h0274, 16'h03FF, 16, 1'b0, 1'b1);  // only 10 valid bits
        xfer(16'h0580, 16'h07FF, 16, 1'b0, 1'b1);  // command 110
        xfer(16'h04E8, 16'h0FFF, 16, 1'b0, 1'b1);  // 12 valid bits
        xfer(16'h0505, 16'h07FF, 11, 1'b1, 1'b1);  // right 5, done with last bit
        xfer(16'h0403, 16'h07FF, 16, 1'b0, 1'b1);  // mix 3
        xfer(16'h048F, 16'h07FF, 16, 1'b0, 1'b1);  // treble 15 -> 12

        xfer(16'h001F, 16'h001F, 5, 1'b0, 1'b0);   // abandoned by restart
        xfer(16'h0449, 16'h07FF, 16, 1'b0, 1'b1);  // bass 9
        chk_settings("after_restart");

        xfer(16'h0024, 16'h003F, 6, 1'b0, 1'b0);   // first 6 bits of treble 10
        @(posedge clk32); #1;
        resb = 1'b0;
        model_reset();
        repeat (2) @(posedge clk32);
        #1;
        resb = 1'b1;
        repeat (3) begin
            @(negedge clk32);
            chk("rst_mid_nopulse", {31'd0, bus.cmd_valid | bus.cmd_err}, 32'd0);
        end
        chk_settings("rst_mid");
        xfer(16'h048A, 16'h07FF, 16, 1'b0, 1'b1);  // treble 10

        repeat (4) @(posedge clk32);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        chk_settings("final");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
